// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port bundle for mem_access_ctrl.
// slave  : the controller (accepts requests, drives the memory port).
// master : the datapath + memory side (issues requests, returns read data).
interface mem_access_ctrl_if;
   // request channel (valid/ready)
   logic        req_vld;
   logic        req_rdy;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_dat;
   // response channel (valid/ready, held until accepted)
   logic        resp_vld;
   logic        resp_rdy;
   logic [15:0] resp_dat;
   logic        resp_err;
   // memory port
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic [15:0] mem_dout;
   logic        mem_oob;

   modport slave (
      input  req_vld, req_write, req_addr, req_dat, resp_rdy, mem_dout, mem_oob,
      output req_rdy, resp_vld, resp_dat, resp_err, mem_addr, mem_din, mem_we
   );

   modport master (
      output req_vld, req_write, req_addr, req_dat, resp_rdy, mem_dout, mem_oob,
      input  req_rdy, resp_vld, resp_dat, resp_err, mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Purpose: single-word load/store initiator for the 16-bit data memory, with OOB write blocking and sticky fault.
// Latency: response valid 2 cycles after request accept; one access per 4 cycles at best.
// Backpressure: req_rdy low from accept until the response is taken; response held stable while resp_rdy is low.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   bus (slave)   - request channel, response channel and memory port
//   fault_clr     - synchronous clear of fault_sticky (a same-cycle fault wins)
//   fault_sticky  - set by any out-of-bounds access
//   busy          - controller is not idle
//   access_count  - completed in-bounds accesses, wraps at 16 bits
module mem_access_ctrl #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic               clk,
   input  logic               rst,
   mem_access_ctrl_if.slave   bus,
   input  logic               fault_clr,
   output logic               fault_sticky,
   output logic               busy,
   output logic [15:0]        access_count
);

   // 17 bits so MEM_WORDS = 65536 still compares correctly
   localparam logic [16:0] ADDR_LIMIT = 17'(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        oob_q, oob_d;
   logic        mem_oob_q, mem_oob_d;
   logic [15:0] resp_dat_q, resp_dat_d;
   logic        resp_err_q, resp_err_d;
   logic        fault_q, fault_d;
   logic [15:0] count_q, count_d;
   logic        capture_err;

   assign capture_err = oob_q | mem_oob_q;

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_vld) state_d = ACCESS;
         ACCESS:  state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP:    if (bus.resp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         oob_q      <= 1'b0;
         mem_oob_q  <= 1'b0;
         resp_dat_q <= '0;
         resp_err_q <= 1'b0;
         fault_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         write_q    <= write_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         oob_q      <= oob_d;
         mem_oob_q  <= mem_oob_d;
         resp_dat_q <= resp_dat_d;
         resp_err_q <= resp_err_d;
         fault_q    <= fault_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      write_d    = write_q;
      addr_d     = addr_q;
      data_d     = data_q;
      oob_d      = oob_q;
      mem_oob_d  = mem_oob_q;
      resp_dat_d = resp_dat_q;
      resp_err_d = resp_err_q;
      fault_d    = fault_q;
      count_d    = count_q;

      if (state_q == IDLE && bus.req_vld) begin
         write_d = bus.req_write;
         addr_d  = bus.req_addr;
         data_d  = bus.req_dat;
         // no address arithmetic: 0xFFFF is simply out of range, never aliased
         oob_d   = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
      end

      // memory's own OOB flag is taken at the same edge that samples the address
      if (state_q == ACCESS) mem_oob_d = bus.mem_oob;

      if (state_q == CAPTURE) begin
         resp_err_d = capture_err;
         resp_dat_d = capture_err ? 16'h0000 : bus.mem_dout;
         if (!capture_err) count_d = count_q + 16'd1;
      end

      // clear first so a fault raised in the same cycle overrides it
      if (fault_clr) fault_d = 1'b0;
      if (state_q == CAPTURE && capture_err) fault_d = 1'b1;
   end

   // ---------------- outputs ----------------
   always_comb begin
      bus.req_rdy  = (state_q == IDLE);
      bus.resp_vld = (state_q == RESP);
      busy         = (state_q != IDLE);
      // combinational from state so reset kills the strobe without a clock
      bus.mem_we   = (state_q == ACCESS) & write_q & ~oob_q;
      // address/data latch only on accept, so they hold outside ACCESS
      bus.mem_addr = addr_q;
      bus.mem_din  = data_q;
      bus.resp_dat = resp_dat_q;
      bus.resp_err = resp_err_q;
      fault_sticky = fault_q;
      access_count = count_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        fault_clr;
   logic        fault_sticky;
   logic        busy;
   logic [15:0] access_count;
   logic        force_oob;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.MEM_WORDS(1024)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .fault_clr    (fault_clr),
      .fault_sticky (fault_sticky),
      .busy         (busy),
      .access_count (access_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- write-first synchronous memory model ----------------
   logic [15:0] mem [0:1023];
   initial for (int i = 0; i < 1024; i++) mem[i] = 16'(i);

   always @(posedge clk) begin
      if (bus.mem_addr < 16'd1024) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_din;
            bus.mem_dout <= bus.mem_din;
         end else begin
            bus.mem_dout <= mem[bus.mem_addr[9:0]];
         end
      end else begin
         bus.mem_dout <= 16'h0000;
      end
   end

   assign bus.mem_oob = force_oob | (bus.mem_addr >= 16'd1024);

   // ---------------- monitors ----------------
   int          we_cnt;
   logic [15:0] last_we_addr;
   logic [15:0] last_we_din;
   int          resp_seen;

   initial begin
      we_cnt = 0;
      resp_seen = 0;
      last_we_addr = '0;
      last_we_din = '0;
   end

   always @(posedge clk) begin
      if (bus.mem_we) begin
         we_cnt++;
         last_we_addr = bus.mem_addr;
         last_we_din  = bus.mem_din;
      end
      if (bus.resp_vld) resp_seen++;
   end

   // ---------------- checking ----------------
   int tests;
   int fails;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request with resp_rdy high; returns response fields and accept->valid latency.
   task automatic do_req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic re, output logic flt,
                         output int lat);
      int n;
      rd = 'x; re = 1'bx; flt = 1'bx; lat = -1;
      @(negedge clk);
      bus.req_vld   = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_dat   = d;
      bus.resp_rdy  = 1'b1;
      n = 0;
      while (!bus.req_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_rdy) begin
         chk("accept_timeout", 32'd0, 32'd1);
         bus.req_vld = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.req_vld = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.resp_vld) break;
      end
      if (!bus.resp_vld) begin
         chk("resp_timeout", 32'd0, 32'd1);
         return;
      end
      rd  = bus.resp_dat;
      re  = bus.resp_err;
      flt = fault_sticky;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp_dat;
      bit          exp_err;
      logic [15:0] exp_cnt;
      bit          exp_fault;
      int          exp_we;
   } vec_t;

   vec_t vecs [13];

   initial begin
      logic [15:0] rd;
      logic        re;
      logic        flt;
      int          lat;
      int          we0;
      int          n;
      logic [15:0] held_dat;
      logic        held_err;

      tests = 0;
      fails = 0;

      //             wr  addr      data      exp_dat   err cnt  flt we
      vecs[0]  = '{1'b0, 16'd23,   16'h0000, 16'd23,   1'b0, 16'd1,  1'b0, 0};
      vecs[1]  = '{1'b0, 16'd1,    16'h0000, 16'd1,    1'b0, 16'd2,  1'b0, 0};
      vecs[2]  = '{1'b0, 16'd63,   16'h0000, 16'd63,   1'b0, 16'd3,  1'b0, 0};
      vecs[3]  = '{1'b0, 16'd654,  16'h0000, 16'd654,  1'b0, 16'd4,  1'b0, 0};
      vecs[4]  = '{1'b0, 16'd1020, 16'h0000, 16'd1020, 1'b0, 16'd5,  1'b0, 0};
      vecs[5]  = '{1'b1, 16'd332,  16'd166,  16'd166,  1'b0, 16'd6,  1'b0, 1};
      vecs[6]  = '{1'b0, 16'd332,  16'h0000, 16'd166,  1'b0, 16'd7,  1'b0, 0};
      vecs[7]  = '{1'b1, 16'd1023, 16'hFFFF, 16'hFFFF, 1'b0, 16'd8,  1'b0, 1};
      vecs[8]  = '{1'b1, 16'd1,    16'hFFFF, 16'hFFFF, 1'b0, 16'd9,  1'b0, 1};
      vecs[9]  = '{1'b0, 16'd1023, 16'h0000, 16'hFFFF, 1'b0, 16'd10, 1'b0, 0};
      vecs[10] = '{1'b0, 16'd1,    16'h0000, 16'hFFFF, 1'b0, 16'd11, 1'b0, 0};
      vecs[11] = '{1'b1, 16'd1024, 16'h1234, 16'h0000, 1'b1, 16'd11, 1'b1, 0};
      vecs[12] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'd11, 1'b1, 0};

      rst = 1'b1;
      fault_clr = 1'b0;
      force_oob = 1'b0;
      bus.req_vld = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr = '0;
      bus.req_dat = '0;
      bus.resp_rdy = 1'b0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_rdy",  32'(bus.req_rdy),  32'd1);
      chk("rst_resp_vld", 32'(bus.resp_vld), 32'd0);
      chk("rst_resp_dat", 32'(bus.resp_dat), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_fault",    32'(fault_sticky), 32'd0);
      chk("rst_busy",     32'(busy),         32'd0);
      chk("rst_count",    32'(access_count), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_din",  32'(bus.mem_din),  32'd0);
      chk("rst_mem_we",   32'(bus.mem_we),   32'd0);
      rst = 1'b0;

      // ---- table-driven accesses ----
      for (int i = 0; i < 13; i++) begin
         we0 = we_cnt;
         do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, re, flt, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("v%0d_dat", i),   32'(rd),  32'(vecs[i].exp_dat));
         chk($sformatf("v%0d_err", i),   32'(re),  32'(vecs[i].exp_err));
         chk($sformatf("v%0d_fault", i), 32'(flt), 32'(vecs[i].exp_fault));
         chk($sformatf("v%0d_count", i), 32'(access_count), 32'(vecs[i].exp_cnt));
         chk($sformatf("v%0d_we_cycles", i), 32'(we_cnt - we0), 32'(vecs[i].exp_we));
         if (vecs[i].exp_we != 0) begin
            chk($sformatf("v%0d_we_addr", i), 32'(last_we_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_we_din", i),  32'(last_we_din),  32'(vecs[i].data));
         end
      end

      // ---- FaultClr pulse clears the sticky flag ----
      @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("fault_clr_pulse", 32'(fault_sticky), 32'd0);

      // ---- FaultClr held during an OOB access: set wins ----
      fault_clr = 1'b1;
      do_req(1'b0, 16'd2000, 16'h0000, rd, re, flt, lat);
      chk("clr_held_fault", 32'(flt), 32'd1);
      chk("clr_held_err",   32'(re),  32'd1);
      fault_clr = 1'b0;
      @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;

      // ---- memory's own OOB flag on an in-range address ----
      force_oob = 1'b1;
      we0 = we_cnt;
      do_req(1'b0, 16'd5, 16'h0000, rd, re, flt, lat);
      force_oob = 1'b0;
      chk("memoob_err",   32'(re),  32'd1);
      chk("memoob_dat",   32'(rd),  32'd0);
      chk("memoob_fault", 32'(flt), 32'd1);
      chk("memoob_count", 32'(access_count), 32'd11);

      // ---- response backpressure with a pending request ----
      @(negedge clk);
      bus.req_vld = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr = 16'd100;
      bus.resp_rdy = 1'b0;
      @(posedge clk);
      #1 bus.req_addr = 16'd200;   // next request held while the first is in flight
      n = 0;
      while (!bus.resp_vld && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_resp_seen", 32'(bus.resp_vld), 32'd1);
      held_dat = bus.resp_dat;
      held_err = bus.resp_err;
      chk("bp_first_dat", 32'(held_dat), 32'd100);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_vld", c), 32'(bus.resp_vld), 32'd1);
         chk($sformatf("bp_hold%0d_dat", c), 32'(bus.resp_dat), 32'd100);
         chk($sformatf("bp_hold%0d_err", c), 32'(bus.resp_err), 32'd0);
         chk($sformatf("bp_hold%0d_rdy", c), 32'(bus.req_rdy),  32'd0);
      end
      bus.resp_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_rdy", 32'(bus.req_rdy),  32'd1);
      chk("bp_idle_vld", 32'(bus.resp_vld), 32'd0);
      @(posedge clk);
      #1;
      bus.req_vld = 1'b0;
      chk("bp_pending_accepted", 32'(busy), 32'd1);
      chk("bp_pending_addr", 32'(bus.mem_addr), 32'd200);
      n = 0;
      while (!bus.resp_vld && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_second_dat", 32'(bus.resp_dat), 32'd200);
      @(posedge clk);
      #1;

      // ---- reset in the middle of a store's ACCESS cycle ----
      @(negedge clk);
      bus.req_vld = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr = 16'd23;
      bus.req_dat = 16'hBEEF;
      @(posedge clk);
      #1 bus.req_vld = 1'b0;
      chk("rst_mid_we_before", 32'(bus.mem_we), 32'd1);
      resp_seen = 0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_we",   32'(bus.mem_we), 32'd0);
      chk("rst_mid_busy", 32'(busy),       32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid_no_resp", 32'(resp_seen), 32'd0);
      chk("rst_mid_count",   32'(access_count), 32'd0);
      do_req(1'b0, 16'd23, 16'h0000, rd, re, flt, lat);
      chk("post_rst_dat",   32'(rd), 32'd23);
      chk("post_rst_err",   32'(re), 32'd0);
      chk("post_rst_count", 32'(access_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-side initiator for the 16-bit data memory. Accepts single-word load/store requests from the datapath over a valid/ready handshake and drives the memory port's address, write data and write-enable. It captures the synchronous read data and returns it on a held response handshake. It blocks out-of-bounds writes before they reach the array and records a sticky fault.

## Interface
- MEM_WORDS, 1024, number of valid word addresses; legal range is 0..MEM_WORDS-1.
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddr  in  16  word address.
- ReqData  in  16  store data; ignored for loads.
- RespValid  out  1  response available.
- RespReady  in  1  consumer accepts response.
- RespData  out  16  load data, or readback of the stored word.
- RespErr  out  1  access was out of bounds.
- FaultSticky  out  1  set by any OOB access; cleared by FaultClr or Reset.
- FaultClr  in  1  synchronous clear of FaultSticky.
- Busy  out  1  state != IDLE.
- AccessCount  out  16  count of completed in-bounds accesses; wraps 0xFFFF -> 0.
- MemAddr  out  16  memory address.
- MemDIn  out  16  memory write data.
- MemWriteEnable  out  1  memory write strobe.
- MemDOut  in  16  memory read data; valid after the posedge that samples MemAddr.
- MemOOB  in  1  memory's own out-of-bounds flag.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE
  - ReqReady=1.
  - When ReqValid at posedge: latch ReqWrite/ReqAddr/ReqData and go to ACCESS.
  - Latch oob = (ReqAddr >= MEM_WORDS).
- ACCESS
  - MemAddr = latched address; MemDIn = latched data.
  - MemWriteEnable = write & ~oob. This is the only state in which MemWriteEnable may be 1.
  - Always go to CAPTURE.
- CAPTURE
  - err = oob | MemOOB (MemOOB sampled at the ACCESS->CAPTURE edge).
  - RespData <= err ? 0 : MemDOut; RespErr <= err; RespValid <= 1.
  - If !err, AccessCount += 1.
  - If err, FaultSticky <= 1.
  - Go to RESP.
- RESP
  - Hold RespValid, RespData and RespErr stable until RespReady at posedge, then go to IDLE and drop RespValid.
- Store readback: the memory is write-first, so RespData for an in-bounds store equals the stored word.
- MemAddr/MemDIn hold their last values outside ACCESS. MemWriteEnable is 0 outside ACCESS.
- FaultSticky
  - FaultClr clears it at posedge.
  - If a fault is set in the same cycle as FaultClr, set wins.
- Reset values
  - State IDLE.
  - ReqReady=1, RespValid=0, RespData=0, RespErr=0, FaultSticky=0, Busy=0, AccessCount=0.
  - MemAddr=0, MemDIn=0, MemWriteEnable=0.

## Timing
- Accept at posedge N (ReqValid & ReqReady).
- ACCESS during cycle N..N+1. The memory samples the address and performs any write at posedge N+1.
- CAPTURE during N+1..N+2. RespValid rises after posedge N+2, so load-to-response latency is 2 cycles.
- Best case, RespReady already high: response consumed at N+3, IDLE from N+3, next request accepted at N+4. Peak throughput is 1 access per 4 cycles.
- ReqReady is 0 from N through the cycle of response acceptance. Requests presented meanwhile are not accepted and must be held by the requester.
- Reset asserted in any state:
  - Immediately forces IDLE and MemWriteEnable=0, with no clock required.
  - A store interrupted in ACCESS is not guaranteed to have reached memory.
  - No response is produced for the aborted request.
- Address wrap: ReqAddr=0xFFFF is OOB, not aliased. No address arithmetic is performed.

## Test plan
- Memory preloaded mem[i]=i. Load ReqAddr=23 -> RespValid 2 cycles after accept, RespData=23, RespErr=0, AccessCount=1. Repeat for 1, 63, 654, 1020 with matching data.
- Store 166 -> 332 -> MemWriteEnable high exactly one cycle with MemAddr=332 and MemDIn=166; RespData=166. A following load of 332 returns 166.
- Store 0xFFFF -> 1023, then store 0xFFFF -> 1, then load both -> each returns 0xFFFF with RespErr=0 (upper bound is in range).
- Store 0x1234 -> 1024 -> MemWriteEnable never asserts; RespErr=1, RespData=0, FaultSticky=1, AccessCount unchanged. Pulse FaultClr -> FaultSticky=0. With FaultClr held during a second OOB access -> FaultSticky=1.
- Hold RespReady=0 for 5 cycles after RespValid -> RespData/RespErr stable; ReqReady=0 while a new ReqValid is held. Raise RespReady -> IDLE, and the pending request is accepted on the next posedge.
- Assert Reset mid-ACCESS of a store -> MemWriteEnable=0 within the same cycle, Busy=0, RespValid never rises. After release, a load of 23 returns 23.
